// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control/status bundle between pwm_capture and the register block.
// master = register block side (drives controls, reads results); slave = pwm_capture.
interface pwm_capture_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cap_en;
  logic             ovf_clr;
  logic [CNT_W-1:0] period_val;
  logic [CNT_W-1:0] high_val;
  logic             meas_valid;
  logic             ovf;
  logic             locked;

  modport master (
    output cap_en,
    output ovf_clr,
    input  period_val,
    input  high_val,
    input  meas_valid,
    input  ovf,
    input  locked
  );

  modport slave (
    input  cap_en,
    input  ovf_clr,
    output period_val,
    output high_val,
    output meas_valid,
    output ovf,
    output locked
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures period (rise to rise) and high time of an asynchronous PWM input in
// clk cycles and publishes each completed period with a one-cycle meas_valid strobe.
// Optional glitch filter: define PWM_CAP_GLITCH_FILTER_EN to suppress pulses shorter than
// 3 cycles (adds 2 cycles of latency to both edges, so measured values are unchanged).
module pwm_capture #(
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StArm, StHigh, StLow} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;

  logic sync_q, s_pwm;
  logic f_pwm, f_d;
  logic rise, fall;

  // Two-flop synchronizer for the asynchronous input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      s_pwm  <= 1'b0;
    end else begin
      sync_q <= pwm_in;
      s_pwm  <= sync_q;
    end
  end

`ifdef PWM_CAP_GLITCH_FILTER_EN
  logic s_d;

  // Accept a new level only once it has been seen on three consecutive samples; looking at
  // the first sync flop too keeps the added latency at 2 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d   <= 1'b0;
      f_pwm <= 1'b0;
    end else begin
      s_d <= s_pwm;
      if ((sync_q == s_pwm) && (s_pwm == s_d)) begin
        f_pwm <= s_pwm;
      end
    end
  end
`else
  assign f_pwm = s_pwm;
`endif

  // Delayed filtered level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_d <= 1'b0;
    end else begin
      f_d <= f_pwm;
    end
  end

  assign rise = f_pwm & ~f_d;
  assign fall = ~f_pwm & f_d;

  // State and measurement registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_lat_q <= hi_lat_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state: edge tracking, counting, result publication and timeout
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_lat_d = hi_lat_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    ovf_set  = 1'b0;

    if (!bus.cap_en) begin
      // Disable overrides any edge this cycle; results and ovf are kept
      state_d  = StIdle;
      cnt_d    = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d    = '0;
          locked_d = 1'b0;
          state_d  = StArm;
        end
        StArm: begin
          // A level already high here is ignored until its next rise
          if (rise) begin
            cnt_d   = CntOne;
            state_d = StHigh;
          end
        end
        StHigh: begin
          if (fall) begin
            hi_lat_d = cnt_q;
            cnt_d    = cnt_q + CntOne;
            state_d  = StLow;
          end else if (cnt_q == CntMax) begin
            ovf_set  = 1'b1;
            locked_d = 1'b0;
            cnt_d    = '0;
            state_d  = StArm;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StLow: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hi_lat_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
            cnt_d    = CntOne;
            state_d  = StHigh;
          end else if (cnt_q == CntMax) begin
            ovf_set  = 1'b1;
            locked_d = 1'b0;
            cnt_d    = '0;
            state_d  = StArm;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    // Sticky overflow: a new timeout beats a simultaneous clear
    ovf_d = ovf_set | (ovf_q & ~bus.ovf_clr);
  end

  assign bus.period_val = period_q;
  assign bus.high_val   = high_q;
  assign bus.meas_valid = valid_q;
  assign bus.locked     = locked_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench. Expected period/high pairs are computed from the driven
// waveform at each rising edge and popped when the DUT strobes meas_valid.
module tb_pwm_capture;

  typedef struct packed {
    logic [15:0] per;
    logic [15:0] hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic pwm_in;
  logic pwm8;

  pwm_capture_if #(.CNT_W(16)) bus16 ();
  pwm_capture_if #(.CNT_W(8))  bus8 ();

  pwm_capture #(.CNT_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .bus    (bus16)
  );

  pwm_capture #(.CNT_W(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm8),
    .bus    (bus8)
  );

  always #5 clk = ~clk;

  exp_t q16[$];
  exp_t q8[$];
  exp_t e16, e8;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_rise = 0;
  int   last_fall = 0;
  bit   track = 1'b0;
  logic [15:0] last_per = '0;
  logic [15:0] last_hi = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the 16-bit instance
  always @(negedge clk) begin
    if (!rst && bus16.meas_valid) begin
      vectors++;
      if (q16.size() == 0) begin
        miscompares++;
        $display("FAIL meas16_unexpected: got %0d/%0d, required no measurement",
                 bus16.period_val, bus16.high_val);
      end else begin
        e16 = q16.pop_front();
        if (bus16.period_val !== e16.per || bus16.high_val !== e16.hi) begin
          miscompares++;
          $display("FAIL meas16: got %0d/%0d, required %0d/%0d",
                   bus16.period_val, bus16.high_val, e16.per, e16.hi);
        end
      end
    end
  end

  // Scoreboard for the 8-bit instance
  always @(negedge clk) begin
    if (!rst && bus8.meas_valid) begin
      vectors++;
      if (q8.size() == 0) begin
        miscompares++;
        $display("FAIL meas8_unexpected: got %0d/%0d, required no measurement",
                 bus8.period_val, bus8.high_val);
      end else begin
        e8 = q8.pop_front();
        if ({8'h00, bus8.period_val} !== e8.per || {8'h00, bus8.high_val} !== e8.hi) begin
          miscompares++;
          $display("FAIL meas8: got %0d/%0d, required %0d/%0d",
                   bus8.period_val, bus8.high_val, e8.per, e8.hi);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function void note_rise();
    exp_t e;
    if (track) begin
      e.per = 16'(cyc - last_rise);
      e.hi  = 16'(last_fall - last_rise);
      q16.push_back(e);
      last_per = e.per;
      last_hi  = e.hi;
    end
    last_rise = cyc;
    track = 1'b1;
  endfunction

  // Hold pwm_in at v for n cycles; model=0 hides the transition from the expectation model
  task automatic drive(input logic v, input int n, input bit model);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (model && v && !pwm_in) note_rise();
      if (model && !v && pwm_in) last_fall = cyc;
      pwm_in = v;
    end
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, hi, 1'b1);
      drive(1'b0, per - hi, 1'b1);
    end
  endtask

  task automatic drain(input bit use8);
    for (int i = 0; i < 40 && (use8 ? q8.size() : q16.size()) != 0; i++) @(negedge clk);
    vectors++;
    if ((use8 ? q8.size() : q16.size()) != 0) begin
      miscompares++;
      $display("FAIL drain%0s: got %0d pending, required 0", use8 ? "8" : "16",
               use8 ? q8.size() : q16.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pwm_in = 1'b0;
    pwm8 = 1'b0;
    bus16.cap_en = 1'b0;
    bus16.ovf_clr = 1'b0;
    bus8.cap_en = 1'b1;
    bus8.ovf_clr = 1'b0;
    #12;
    vectors++;
    if ({bus16.period_val, bus16.high_val, bus16.meas_valid, bus16.ovf, bus16.locked} !== '0)
    begin
      miscompares++;
      $display("FAIL reset_outputs: got %0d/%0d v%0b o%0b l%0b, required all 0",
               bus16.period_val, bus16.high_val, bus16.meas_valid, bus16.ovf, bus16.locked);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bus16.cap_en = 1'b1;
    drive(1'b0, 3, 1'b1);
    wave(10, 3, 6);
    drain(1'b0);
    vectors++;
    if (bus16.locked !== 1'b1 || bus16.period_val !== 16'd10 || bus16.high_val !== 16'd3) begin
      miscompares++;
      $display("FAIL basic_final: got l%0b %0d/%0d, required l1 10/3",
               bus16.locked, bus16.period_val, bus16.high_val);
    end
  endtask

  task automatic test_duty_change();
    int per, hi;
`ifdef PWM_CAP_GLITCH_FILTER_EN
    per = 9;
`else
    per = 7;
`endif
    hi = 6;
    wave(per, hi, 4);
    drain(1'b0);
    vectors++;
    if (bus16.period_val !== 16'(per) || bus16.high_val !== 16'(hi)) begin
      miscompares++;
      $display("FAIL duty_change: got %0d/%0d, required %0d/%0d",
               bus16.period_val, bus16.high_val, per, hi);
    end
  endtask

  task automatic test_disable();
    drive(1'b1, 4, 1'b1);
    bus16.cap_en = 1'b0;
    track = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus16.locked !== 1'b0 || bus16.period_val !== last_per || bus16.high_val !== last_hi)
    begin
      miscompares++;
      $display("FAIL disable_hold: got l%0b %0d/%0d, required l0 %0d/%0d",
               bus16.locked, bus16.period_val, bus16.high_val, last_per, last_hi);
    end
    drive(1'b1, 3, 1'b1);
    bus16.cap_en = 1'b1;
    drive(1'b1, 5, 1'b1);
    vectors++;
    if (bus16.locked !== 1'b0) begin
      miscompares++;
      $display("FAIL reenable_locked: got %0b, required 0", bus16.locked);
    end
    drive(1'b0, 5, 1'b1);
    wave(10, 4, 3);
    drain(1'b0);
    vectors++;
    if (bus16.locked !== 1'b1) begin
      miscompares++;
      $display("FAIL reenable_relock: got %0b, required 1", bus16.locked);
    end
  endtask

  task automatic test_filter();
    bit gm;
`ifdef PWM_CAP_GLITCH_FILTER_EN
    gm = 1'b0;
`else
    gm = 1'b1;
`endif
    drive(1'b1, 8, 1'b1);
    drive(1'b0, 5, 1'b1);
    drive(1'b1, 2, gm);
    drive(1'b0, 5, gm);
    wave(20, 8, 2);
    drain(1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5, 1'b1);
    drain(1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus16.period_val, bus16.high_val, bus16.meas_valid, bus16.ovf, bus16.locked} !== '0)
    begin
      miscompares++;
      $display("FAIL async_reset: got %0d/%0d v%0b o%0b l%0b, required all 0",
               bus16.period_val, bus16.high_val, bus16.meas_valid, bus16.ovf, bus16.locked);
    end
    pwm_in = 1'b0;
    track = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wave(10, 5, 3);
    drain(1'b0);
    vectors++;
    if (bus16.period_val !== 16'd10 || bus16.high_val !== 16'd5) begin
      miscompares++;
      $display("FAIL post_reset_meas: got %0d/%0d, required 10/5",
               bus16.period_val, bus16.high_val);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    @(negedge clk);
    pwm8 = 1'b1;
    repeat (257) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus8.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_early: got %0b, required 0", bus8.ovf);
    end
    @(negedge clk);
    vectors++;
    if (bus8.ovf !== 1'b1 || bus8.locked !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_set: got o%0b l%0b, required o1 l0", bus8.ovf, bus8.locked);
    end
    bus8.ovf_clr = 1'b1;
    @(negedge clk);
    bus8.ovf_clr = 1'b0;
    vectors++;
    if (bus8.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clr: got %0b, required 0", bus8.ovf);
    end
    // Back in ARM: the first rise only arms, the second completes a 7/3 period
    pwm8 = 1'b0;
    repeat (4) @(negedge clk);
    pwm8 = 1'b1;
    repeat (3) @(negedge clk);
    pwm8 = 1'b0;
    repeat (4) @(negedge clk);
    e.per = 16'd7;
    e.hi  = 16'd3;
    q8.push_back(e);
    pwm8 = 1'b1;
    repeat (3) @(negedge clk);
    pwm8 = 1'b0;
    drain(1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty_change();
    test_disable();
    test_filter();
    test_timeout();
    test_async_reset();
    vectors++;
    if (q16.size() != 0 || q8.size() != 0) begin
      miscompares++;
      $display("FAIL final_queues: got %0d/%0d pending, required 0/0", q16.size(), q8.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
